// File: rtl/ktc32_pkg.sv
// Shared constants, instruction layout and address decode for the ktc32 core.
package ktc32_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RAM_WORDS = 4096;
  localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
  localparam int unsigned OPC_W     = 6;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned IMM_W     = 16;
  localparam int unsigned LED_W     = 4;

  localparam logic [XLEN-1:0] LED_ADDR = 32'h8000_0000;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD  = 6'h00,
    OP_SUB  = 6'h01,
    OP_AND  = 6'h02,
    OP_OR   = 6'h03,
    OP_XOR  = 6'h04,
    OP_ADDI = 6'h08,
    OP_LUI  = 6'h09,
    OP_LW   = 6'h10,
    OP_SW   = 6'h11,
    OP_BEQ  = 6'h18,
    OP_BNE  = 6'h19,
    OP_JAL  = 6'h1A,
    OP_JALR = 6'h1B
  } opcode_e;

  // rs2 overlays the top five bits of imm
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [IMM_W-1:0]  imm;
  } instr_t;

  typedef enum logic [1:0] {
    REGION_NONE = 2'd0,
    REGION_RAM  = 2'd1,
    REGION_LED  = 2'd2
  } region_e;

  function automatic region_e decode_addr(input logic [XLEN-1:0] addr);
    region_e region;
    region = REGION_NONE;
    if (addr[XLEN-1:RAM_AW+2] == '0) begin
      region = REGION_RAM;
    end else if ({addr[XLEN-1:2], 2'b00} == LED_ADDR) begin
      region = REGION_LED;
    end
    return region;
  endfunction

endpackage

// File: rtl/ktc32_ram.sv
// Unified instruction/data RAM: two combinational read ports, one synchronous write port.
module ktc32_ram
  import ktc32_pkg::*;
(
  input  logic              clk,
  input  logic [RAM_AW-1:0] iaddr_i,
  output logic [XLEN-1:0]   irdata_c_o,
  input  logic [RAM_AW-1:0] daddr_i,
  output logic [XLEN-1:0]   drdata_c_o,
  input  logic              we_i,
  input  logic [XLEN-1:0]   wdata_i
);

  logic [XLEN-1:0] mem [RAM_WORDS];

  assign irdata_c_o = mem[iaddr_i];
  assign drdata_c_o = mem[daddr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[daddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/arty_s7_top.sv
// Arty S7 top: single-cycle ktc32 core, unified RAM and a memory-mapped LED register.
module arty_s7_top
  import ktc32_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  output logic [LED_W-1:0] led
);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   regs_q [NUM_REGS];
  logic [LED_W-1:0]  led_q;

  logic [XLEN-1:0]   irdata, drdata, instr_word;
  instr_t            instr;
  logic [REG_AW-1:0] rs2_idx;
  logic [XLEN-1:0]   sext, rd_val, rs1_val, rs2_val;
  logic [XLEN-1:0]   pc_plus4, br_target, dmem_addr, load_data;
  region_e           dmem_region;
  logic              rd_we, st_en, ram_we, led_we;
  logic [XLEN-1:0]   rd_wdata;
  logic              unused_c;

  ktc32_ram ram (
    .clk        (clk),
    .iaddr_i    (pc_q[RAM_AW+1:2]),
    .irdata_c_o (irdata),
    .daddr_i    (dmem_addr[RAM_AW+1:2]),
    .drdata_c_o (drdata),
    .we_i       (ram_we),
    .wdata_i    (rd_val)
  );

  // Fetch outside RAM yields an all-zero word, which executes as a NOP
  assign instr_word = (decode_addr(pc_q) == REGION_RAM) ? irdata : '0;
  assign instr      = instr_t'(instr_word);
  assign rs2_idx    = instr.imm[IMM_W-1 -: REG_AW];
  assign sext       = {{(XLEN-IMM_W){instr.imm[IMM_W-1]}}, instr.imm};

  assign rd_val  = regs_q[instr.rd];
  assign rs1_val = regs_q[instr.rs1];
  assign rs2_val = regs_q[rs2_idx];

  assign pc_plus4    = pc_q + XLEN'(4);
  assign br_target   = pc_plus4 + {sext[XLEN-3:0], 2'b00};
  assign dmem_addr   = rs1_val + sext;
  assign dmem_region = decode_addr(dmem_addr);
  assign unused_c    = ^{pc_q[1:0], dmem_addr[1:0]};

  always_comb begin
    load_data = '0;
    case (dmem_region)
      REGION_RAM: load_data = drdata;
      REGION_LED: load_data = XLEN'(led_q);
      default:    load_data = '0;
    endcase
  end

  // Decode/execute: next pc, register writeback and store enable
  always_comb begin
    pc_d     = pc_plus4;
    rd_we    = 1'b0;
    rd_wdata = '0;
    st_en    = 1'b0;
    case (instr.opcode)
      OP_ADD:  begin rd_we = 1'b1; rd_wdata = rs1_val + rs2_val; end
      OP_SUB:  begin rd_we = 1'b1; rd_wdata = rs1_val - rs2_val; end
      OP_AND:  begin rd_we = 1'b1; rd_wdata = rs1_val & rs2_val; end
      OP_OR:   begin rd_we = 1'b1; rd_wdata = rs1_val | rs2_val; end
      OP_XOR:  begin rd_we = 1'b1; rd_wdata = rs1_val ^ rs2_val; end
      OP_ADDI: begin rd_we = 1'b1; rd_wdata = rs1_val + sext; end
      OP_LUI:  begin rd_we = 1'b1; rd_wdata = {instr.imm, {(XLEN-IMM_W){1'b0}}}; end
      OP_LW:   begin rd_we = 1'b1; rd_wdata = load_data; end
      OP_SW:   st_en = 1'b1;
      OP_BEQ:  if (rd_val == rs1_val) pc_d = br_target;
      OP_BNE:  if (rd_val != rs1_val) pc_d = br_target;
      OP_JAL:  begin rd_we = 1'b1; rd_wdata = pc_plus4; pc_d = br_target; end
      OP_JALR: begin rd_we = 1'b1; rd_wdata = pc_plus4; pc_d = {dmem_addr[XLEN-1:2], 2'b00}; end
      default: ;
    endcase
  end

  // RAM is not reset, so block stores while reset holds the core
  assign ram_we = st_en & (dmem_region == REGION_RAM) & ~reset;
  assign led_we = st_en & (dmem_region == REGION_LED);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= '0;
      regs_q <= '{default: '0};
      led_q  <= '0;
    end else begin
      pc_q <= pc_d;
      if (rd_we && (instr.rd != '0)) begin
        regs_q[instr.rd] <= rd_wdata;
      end
      if (led_we) begin
        led_q <= rd_val[LED_W-1:0];
      end
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_arty_s7_top.sv
// Directed and random programs on arty_s7_top, checked against an instruction-level model.
module tb_arty_s7_top;

  localparam logic [5:0] ADD = 6'h00, SUB = 6'h01, AND_ = 6'h02, OR_ = 6'h03, XOR_ = 6'h04;
  localparam logic [5:0] ADDI = 6'h08, LUI = 6'h09, LW = 6'h10, SW = 6'h11;
  localparam logic [5:0] BEQ = 6'h18, BNE = 6'h19, JAL = 6'h1A, JALR = 6'h1B;
  localparam logic [31:0] LED_A = 32'h8000_0000;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] led;

  arty_s7_top dut (.clk(clk), .reset(reset), .led(led));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_mem  [4096];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [3:0]  m_led;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'h0};
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] r);
    return (r == 5'd0) ? 32'h0 : m_regs[r];
  endfunction

  task automatic m_wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_regs[r] = v;
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_led = 4'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  endtask

  // Architectural meaning of one instruction
  task automatic model_step();
    logic [31:0] ins, a, b, c, s, ea, nxt;
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    ins = (m_pc < 32'h4000) ? m_mem[m_pc[13:2]] : 32'h0;
    op  = ins[31:26];
    rd  = ins[25:21];
    rs1 = ins[20:16];
    rs2 = ins[15:11];
    s   = 32'($signed(ins[15:0]));
    a   = m_rd(rd);
    b   = m_rd(rs1);
    c   = m_rd(rs2);
    ea  = b + s;
    nxt = m_pc + 32'd4;
    case (op)
      ADD:  m_wr(rd, b + c);
      SUB:  m_wr(rd, b - c);
      AND_: m_wr(rd, b & c);
      OR_:  m_wr(rd, b | c);
      XOR_: m_wr(rd, b ^ c);
      ADDI: m_wr(rd, b + s);
      LUI:  m_wr(rd, {ins[15:0], 16'h0});
      LW: begin
        if (ea < 32'h4000)                  m_wr(rd, m_mem[ea[13:2]]);
        else if ((ea & ~32'h3) == LED_A)    m_wr(rd, {28'h0, m_led});
        else                                m_wr(rd, 32'h0);
      end
      SW: begin
        if (ea < 32'h4000)                  m_mem[ea[13:2]] = a;
        else if ((ea & ~32'h3) == LED_A)    m_led = a[3:0];
      end
      BEQ:  if (a == b) nxt = m_pc + 32'd4 + (s << 2);
      BNE:  if (a != b) nxt = m_pc + 32'd4 + (s << 2);
      JAL:  begin m_wr(rd, m_pc + 32'd4); nxt = m_pc + 32'd4 + (s << 2); end
      JALR: begin m_wr(rd, m_pc + 32'd4); nxt = ea & ~32'h3; end
      default: ;
    endcase
    m_pc = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else       model_step();
    #1;
    check("led_track", {28'h0, led}, {28'h0, m_led});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic load(input logic [31:0] prog [$]);
    logic [31:0] w;
    for (int i = 0; i < 4096; i++) begin
      w = (i < prog.size()) ? prog[i] : 32'h0;
      dut.ram.mem[i] <= w;
      m_mem[i] = w;
    end
  endtask

  task automatic start(input logic [31:0] prog [$]);
    reset = 1'b1;
    load(prog);
    tick();
    tick();
    check("rst_led", {28'h0, led}, 32'h0);
    check("rst_pc", dut.pc_q, 32'h0);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr(input int idx);
    logic [4:0] rd, rs1, rs2;
    int sel;
    rd  = 5'($urandom_range(0, 7));
    if (rd == 5'd1) rd = 5'd0;
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    sel = $urandom_range(0, 13);
    case (sel)
      0, 1, 2, 3, 4: return enc_r(6'(sel), rd, rs1, rs2);
      5:  return enc(ADDI, rd, rs1, 16'($urandom));
      6:  return enc(LUI, rd, 5'd0, 16'($urandom));
      7:  if ($urandom_range(0, 3) == 0) return enc(LW, rd, 5'd1, 16'h0);
          else return enc(LW, rd, 5'd0, 16'(32'h200 + 4 * $urandom_range(0, 63)));
      8, 9: if ($urandom_range(0, 1) == 0) return enc(SW, rs2, 5'd1, 16'h0);
          else return enc(SW, rs2, 5'd0, 16'(32'h200 + 4 * $urandom_range(0, 63)));
      10: return enc(($urandom_range(0, 1) == 0) ? BEQ : BNE, rs2, rs1, 16'($urandom_range(0, 3)));
      11: return enc(JAL, rd, 5'd0, 16'($urandom_range(0, 3)));
      12: return enc(JALR, rd, 5'd0, 16'(4 * $urandom_range(61, idx + 1)));
      default: return enc(($urandom_range(0, 1) == 0) ? 6'h05 : 6'h3E, rd, rs1, 16'($urandom));
    endcase
  endfunction

  logic [31:0] p [$];
  logic [31:0] halt;
  logic [31:0] w0;

  initial begin
    reset = 1'b1;
    halt  = enc(BEQ, 5'd0, 5'd0, 16'hFFFF);

    // LED write and low-nibble truncation
    p = {enc(LUI, 1, 0, 16'h8000), enc(ADDI, 2, 0, 16'd5), enc(SW, 2, 1, 16'h0),
         enc(ADDI, 2, 0, 16'h1F), enc(SW, 2, 1, 16'h0), halt};
    start(p);
    run(3);
    check("led_5", {28'h0, led}, 32'h5);
    run(2);
    check("led_f", {28'h0, led}, 32'hF);
    run(3);

    // Counter loop with wrap, then reset mid-loop
    p = {enc(LUI, 1, 0, 16'h8000), enc(ADDI, 2, 0, 16'h0), enc(ADDI, 2, 2, 16'h1),
         enc(SW, 2, 1, 16'h0), enc(BNE, 2, 0, 16'hFFFD)};
    start(p);
    run(3);
    for (int i = 1; i <= 16; i++) begin
      run(1);
      check("counter", {28'h0, led}, 32'(i % 16));
      run(2);
    end
    reset = 1'b1;
    tick();
    check("midrst_led", {28'h0, led}, 32'h0);
    check("midrst_pc", dut.pc_q, 32'h0);
    reset = 1'b0;
    run(3);
    run(1);
    check("restart_cnt", {28'h0, led}, 32'h1);
    run(5);

    // RAM round trip and unmapped accesses
    w0 = enc(ADDI, 3, 0, 16'h1234);
    p = {w0, enc(SW, 3, 0, 16'h0100), enc(LW, 4, 0, 16'h0100), enc(LUI, 1, 0, 16'h8000),
         enc(SW, 4, 1, 16'h0), enc(LUI, 5, 0, 16'h4000), enc(LW, 6, 5, 16'h0),
         enc(SW, 6, 1, 16'h0), enc(SW, 3, 5, 16'h0), halt};
    start(p);
    run(5);
    check("ram_rt_led", {28'h0, led}, 32'h4);
    check("ram_word", dut.ram.mem[64], 32'h1234);
    run(3);
    check("unmapped_lw", {28'h0, led}, 32'h0);
    run(2);
    check("unmapped_sw", dut.ram.mem[0], w0);

    // Branches, JAL link value, r0 hardwired
    p = {enc(LUI, 1, 0, 16'h8000), enc(ADDI, 2, 0, 16'd3), enc(ADDI, 3, 0, 16'd3),
         enc(BEQ, 2, 3, 16'd1), enc(ADDI, 4, 0, 16'd9), enc(ADDI, 4, 4, 16'd6),
         enc(SW, 4, 1, 16'h0), enc(ADDI, 3, 0, 16'd4), enc(BEQ, 2, 3, 16'd1),
         enc(ADDI, 4, 0, 16'd2), enc(SW, 4, 1, 16'h0), enc(6'h3F, 5, 5, 16'hFFFF),
         enc(JAL, 7, 0, 16'd1), enc(ADDI, 7, 0, 16'd1), enc(SW, 7, 1, 16'h0),
         enc(ADDI, 0, 0, 16'd7), enc(SW, 0, 1, 16'h0), halt};
    start(p);
    run(6);
    check("beq_taken", {28'h0, led}, 32'h6);
    run(4);
    check("beq_not_taken", {28'h0, led}, 32'h2);
    run(3);
    check("jal_link_led", {28'h0, led}, 32'h4);
    check("jal_link_reg", dut.regs_q[7], 32'd52);
    run(2);
    check("r0_led", {28'h0, led}, 32'h0);
    check("r0_reg", dut.regs_q[0], 32'h0);
    run(2);

    // Random programs against the model
    for (int t = 0; t < 6; t++) begin
      p = {enc(LUI, 1, 0, 16'h8000)};
      for (int j = 1; j <= 60; j++) p.push_back(rand_instr(j));
      p.push_back(halt);
      start(p);
      run(200);
      check("rand_pc", dut.pc_q, m_pc);
      for (int r = 1; r < 32; r++) check("rand_reg", dut.regs_q[r], m_regs[r]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arty_s7_top.md
Name: arty_s7_top

Overview:
- FPGA top level for the Arty S7 board.
- Contains a minimal single-cycle 32-bit processor, a unified instruction/data RAM and a memory-mapped 4-bit LED register.
- The program image is preloaded into the RAM as hex words. The board LEDs show whatever the program last wrote to the LED address.

Parameters:
- RAM_WORDS, 4096, number of 32-bit RAM words (16 KiB, byte addresses 0x0000_0000–0x0000_3FFF).
- LED_ADDR, 32'h8000_0000, byte address of the LED register.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- led  output  4  board LEDs; driven directly from the LED register.

Behaviour:
- Reset (synchronous, active-high, takes effect on the clock edge while asserted):
  - pc=0, all 32 registers=0, led=4'b0000.
  - RAM contents are not cleared, so a reset mid-program restarts execution at address 0 with the preloaded image intact.
- Single-cycle execution, one instruction per clk:
  - Instruction fetch is a combinational read of RAM at pc[13:2].
  - Register write, RAM write, LED write and pc update all occur on the same rising edge.
- Instruction format:
  - [31:26] opcode, [25:21] rd, [20:16] rs1, [15:11] rs2, [15:0] imm16.
  - sext = sign-extend imm16 to 32 bits.
- Opcodes (arithmetic wraps modulo 2^32):
  - 0x00 ADD rd=rs1+rs2
  - 0x01 SUB rd=rs1-rs2
  - 0x02 AND
  - 0x03 OR
  - 0x04 XOR
  - 0x08 ADDI rd=rs1+sext
  - 0x09 LUI rd={imm16,16'h0}
  - 0x10 LW rd=load(rs1+sext)
  - 0x11 SW store(rs1+sext, rd)
  - 0x18 BEQ: if rd==rs1, pc=pc+4+(sext<<2)
  - 0x19 BNE: if rd!=rs1, pc=pc+4+(sext<<2)
  - 0x1A JAL: rd=pc+4; pc=pc+4+(sext<<2)
  - 0x1B JALR: rd=pc+4; pc=(rs1+sext)&~3
  - Any other opcode executes as a NOP (pc+=4).
- Register r0 always reads 0; writes to r0 are discarded.
- pc increments by 4 when no branch/jump is taken.
- Addresses are word aligned; address bits [1:0] are ignored.
- Data memory map:
  - RAM: addr[31:14]==0; word index addr[13:2]. Read is combinational; write is synchronous.
  - LED: addr==LED_ADDR. SW sets led=data[3:0]. LW returns {28'h0,led}.
  - Any other address: LW returns 0, SW is ignored.
- Instruction fetch with pc outside RAM returns 0 (ADD r0,r0,r0, i.e. a NOP), so pc keeps advancing.
- The RAM array is reachable by hierarchical path ram.mem (instance "ram", array "mem", 32-bit words, index 0..RAM_WORDS-1) so a bench can load it with $readmemh.
- Only one data access per cycle, so there is no read/write conflict. LW of an address being stored in the same cycle cannot occur.

Decomposition:
- Package ktc32_pkg:
  - opcode enum
  - instruction field widths
  - RAM_WORDS and LED_ADDR constants
  - memory-map decode helper function
- Sub-module ktc32_ram, instantiated as "ram":
  - array mem
  - two combinational read ports (instruction, data)
  - one synchronous write port
- Processor datapath (register file, ALU, branch unit, pc) and LED register live in arty_s7_top.

Test Plan:
- Reset: hold reset=1 two cycles → led=0, pc=0. Release → first instruction executes on the next edge.
- LED write: program "LUI r1,0x8000; ADDI r2,r0,5; SW r2,0(r1)" → led=4'h5 after the 3rd edge. Overwriting with 0x1F → led=4'hF (only low bits kept).
- Counter loop: program increments r2, stores it to LED, then BNE back. Over 16 iterations led steps 1,2,…,F,0 (wrap).
- RAM round trip: "ADDI r3,r0,0x1234; SW r3,0x100(r0); LW r4,0x100(r0); SW r4 to LED" → led=4'h4. LW from 0x4000_0000 → 0.
- Branch/jump/r0:
  - BEQ taken vs not taken selects which value reaches the LEDs.
  - JAL writes pc+4 to its rd.
  - ADDI r0,r0,7 followed by SW r0 to LED → led=0.
- Reset mid-program: assert reset while the loop is running → led=0 on the next edge. The counter restarts from 1 after release (RAM image intact).
